// File: rtl/draw_pkg.sv
// Shared timing defaults, total-length helpers, colour type and reset palette
// for the framebuffer scanout path.
package draw_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   typedef logic [11:0] rgb12_t;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   // Index 0 is black so an empty framebuffer scans out dark.
   function automatic rgb12_t reset_palette(input int idx);
      return (idx == 0) ? 12'h000 : 12'hFFF;
   endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
module bram_sdp #(
   parameter int    WIDTH  = 8,
   parameter int    DEPTH  = 256,
   parameter string INIT_F = "",
   localparam int   ADDRW  = $clog2(DEPTH)
) (
   input  logic             clk_write,
   input  logic             clk_read,
   input  logic             we,
   input  logic [ADDRW-1:0] addr_write,
   input  logic [ADDRW-1:0] addr_read,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   // INIT_F preload is left to the target's memory-init flow.
   logic [WIDTH-1:0] memory [DEPTH];

   always_ff @(posedge clk_write) begin
      if (we) memory[addr_write] <= data_in;
   end

   always_ff @(posedge clk_read) begin
      data_out <= memory[addr_read];
   end

endmodule

// File: rtl/draw_timing.sv
// Raster counters, active-low syncs, active flag and the vblank_start pulse,
// all combinational from the current counter state.
module draw_timing
   import draw_pkg::*;
#(
   parameter int  H_ACTIVE = H_ACTIVE_DEF,
   parameter int  H_FP     = H_FP_DEF,
   parameter int  H_SYNC   = H_SYNC_DEF,
   parameter int  H_BP     = H_BP_DEF,
   parameter int  V_ACTIVE = V_ACTIVE_DEF,
   parameter int  V_FP     = V_FP_DEF,
   parameter int  V_SYNC   = V_SYNC_DEF,
   parameter int  V_BP     = V_BP_DEF,
   localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          reset_n,
   output logic [HW-1:0] h,
   output logic [VW-1:0] v,
   output logic          active,
   output logic          hs,
   output logic          vs,
   output logic          vblank_start
);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + VW'(1);
      end else begin
         h <= h + HW'(1);
      end
   end

   always_comb begin
      active       = (h < H_ACT) && (v < V_ACT);
      hs           = !((h >= HS_BEG) && (h < HS_END));
      vs           = !((v >= VS_BEG) && (v < VS_END));
      vblank_start = (h == '0) && (v == V_ACT);
   end

endmodule

// File: rtl/draw_fb.sv
// Double-buffered, palette-indexed framebuffer scanout with integer upscaling
// and swaps aligned to vblank; three-stage pipeline from counters to pins.
module draw_fb
   import draw_pkg::*;
#(
   parameter int    H_ACTIVE  = H_ACTIVE_DEF,
   parameter int    H_FP      = H_FP_DEF,
   parameter int    H_SYNC    = H_SYNC_DEF,
   parameter int    H_BP      = H_BP_DEF,
   parameter int    V_ACTIVE  = V_ACTIVE_DEF,
   parameter int    V_FP      = V_FP_DEF,
   parameter int    V_SYNC    = V_SYNC_DEF,
   parameter int    V_BP      = V_BP_DEF,
   parameter int    SCALE     = 1,
   parameter int    DATAW     = 1,
   parameter string INIT_F    = "",
   localparam int   FB_WIDTH  = H_ACTIVE / SCALE,
   localparam int   FB_HEIGHT = V_ACTIVE / SCALE,
   localparam int   FB_SIZE   = FB_WIDTH * FB_HEIGHT,
   localparam int   FB_ADDRW  = $clog2(FB_SIZE)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [FB_ADDRW-1:0] wr_addr,
   input  logic [DATAW-1:0]    wr_data,
   input  logic                wr_we,
   input  logic                swap_req,
   output logic                swap_pending,
   output logic                front_sel,
   output logic                vblank_start,
   input  logic                pal_we,
   input  logic [DATAW-1:0]    pal_idx,
   input  logic [11:0]         pal_rgb,
   output logic [3:0]          vga_r,
   output logic [3:0]          vga_g,
   output logic [3:0]          vga_b,
   output logic                vga_hs,
   output logic                vga_vs
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int PAL_N   = 2 ** DATAW;

   localparam logic [SW-1:0]       SUB_LAST = SW'(SCALE - 1);
   localparam logic [HW-1:0]       H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]       V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [FB_ADDRW-1:0] ROW_STEP = FB_ADDRW'(FB_WIDTH);

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          active0, hs0, vs0;

   draw_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk          (clk),
      .reset_n      (reset_n),
      .h            (h),
      .v            (v),
      .active       (active0),
      .hs           (hs0),
      .vs           (vs0),
      .vblank_start (vblank_start)
   );

   // Stage 0: address counters stepped alongside h/v; fb_x = h/SCALE and
   // row_base = (v/SCALE)*FB_WIDTH without multipliers. Wraps in blanking are harmless.
   logic [SW-1:0]       sub_x, sub_y;
   logic [FB_ADDRW-1:0] fb_x, row_base;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sub_x    <= '0;
         sub_y    <= '0;
         fb_x     <= '0;
         row_base <= '0;
      end else if (h == H_LAST) begin
         sub_x <= '0;
         fb_x  <= '0;
         if (v == V_LAST) begin
            sub_y    <= '0;
            row_base <= '0;
         end else if (sub_y == SUB_LAST) begin
            sub_y    <= '0;
            row_base <= row_base + ROW_STEP;
         end else begin
            sub_y <= sub_y + SW'(1);
         end
      end else if (sub_x == SUB_LAST) begin
         sub_x <= '0;
         fb_x  <= fb_x + FB_ADDRW'(1);
      end else begin
         sub_x <= sub_x + SW'(1);
      end
   end

   // Stages 1 and 2: registered read address, then BRAM data; controls ride alongside.
   logic [FB_ADDRW-1:0] rd_addr;
   logic                act1, hs1, vs1, sel1;
   logic                act2, hs2, vs2, sel2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr <= '0;
         act1    <= 1'b0;
         hs1     <= 1'b1;
         vs1     <= 1'b1;
         sel1    <= 1'b0;
         act2    <= 1'b0;
         hs2     <= 1'b1;
         vs2     <= 1'b1;
         sel2    <= 1'b0;
      end else begin
         rd_addr <= row_base + fb_x;
         act1    <= active0;
         hs1     <= hs0;
         vs1     <= vs0;
         sel1    <= front_sel;
         act2    <= act1;
         hs2     <= hs1;
         vs2     <= vs1;
         sel2    <= sel1;
      end
   end

   logic [DATAW-1:0] rd_data0, rd_data1, pix2;

   bram_sdp #(.WIDTH(DATAW), .DEPTH(FB_SIZE), .INIT_F(INIT_F)) u_buf0 (
      .clk_write  (clk),
      .clk_read   (clk),
      .we         (wr_we & front_sel),
      .addr_write (wr_addr),
      .addr_read  (rd_addr),
      .data_in    (wr_data),
      .data_out   (rd_data0)
   );

   bram_sdp #(.WIDTH(DATAW), .DEPTH(FB_SIZE), .INIT_F("")) u_buf1 (
      .clk_write  (clk),
      .clk_read   (clk),
      .we         (wr_we & ~front_sel),
      .addr_write (wr_addr),
      .addr_read  (rd_addr),
      .data_in    (wr_data),
      .data_out   (rd_data1)
   );

   assign pix2 = sel2 ? rd_data1 : rd_data0;

   rgb12_t pal [PAL_N];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PAL_N; i++) pal[i] <= reset_palette(i);
      end else if (pal_we) begin
         pal[pal_idx] <= pal_rgb;
      end
   end

   // Stage 3: palette lookup straight onto the pins, blanked outside the active area.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {vga_r, vga_g, vga_b} <= 12'h000;
         vga_hs                <= 1'b1;
         vga_vs                <= 1'b1;
      end else begin
         {vga_r, vga_g, vga_b} <= act2 ? pal[pix2] : 12'h000;
         vga_hs                <= hs2;
         vga_vs                <= vs2;
      end
   end

   // swap_req is a one-cycle strobe; swap_pending holds it until the flip at
   // vblank_start, and a strobe on that very cycle waits for the next vblank.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
      end else if (vblank_start && swap_pending) begin
         front_sel    <= ~front_sel;
         swap_pending <= swap_req;
      end else if (swap_req) begin
         swap_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_draw_fb.sv
// Randomised bench for draw_fb on a shrunken raster; every pin is compared each
// cycle against a frame-arithmetic model of what the screen should show.
module tb_draw_fb;

   localparam int HA = 16, HFP = 2, HSY = 4, HBP = 2;
   localparam int VA = 12, VFP = 1, VSY = 2, VBP = 1;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;
   localparam int SC = 2, DW = 4;
   localparam int FBW = HA / SC, FBH = VA / SC, FBS = FBW * FBH;
   localparam int AW = $clog2(FBS);
   localparam int PN = 2 ** DW;
   localparam int VBS2 = 2 * FRAME + VA * HT;

   logic          clk, reset_n;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data, pal_idx;
   logic          wr_we, swap_req, pal_we;
   logic [11:0]   pal_rgb;
   logic          swap_pending, front_sel, vblank_start;
   logic [3:0]    vga_r, vga_g, vga_b;
   logic          vga_hs, vga_vs;

   draw_fb #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .SCALE(SC), .DATAW(DW), .INIT_F("")
   ) dut (
      .clk(clk), .reset_n(reset_n), .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we),
      .swap_req(swap_req), .swap_pending(swap_pending), .front_sel(front_sel),
      .vblank_start(vblank_start), .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
   );

   // ---- clock / reset ----
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- reference model and scoreboard state ----
   logic [DW-1:0] mem_m   [2][FBS];
   bit            known_m [2][FBS];
   logic [11:0]   pal_m   [PN];
   bit            front_m, pending_m, seg_b;
   int            n, fill_idx;
   logic [14:0]   exp_q[$];
   int            n_cmp, n_bad, vbs_seen, vbs_exp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   function automatic bit is_active(input int c);
      return ((c % HT) < HA) && (((c / HT) % VT) < VA);
   endfunction

   // Pins expected for the raster position reached c cycles after reset:
   // {rgb_checkable, hs, vs, rgb}.
   function automatic logic [14:0] model_pins(input int c);
      int          hh, vv, a;
      bit          hs, vs, chk;
      logic [11:0] rgb;
      hh  = c % HT;
      vv  = (c / HT) % VT;
      hs  = !(hh >= HA + HFP && hh < HA + HFP + HSY);
      vs  = !(vv >= VA + VFP && vv < VA + VFP + VSY);
      rgb = 12'h000;
      chk = 1'b1;
      if (is_active(c)) begin
         a   = (vv / SC) * FBW + hh / SC;
         chk = known_m[front_m][a];
         if (chk) rgb = pal_m[mem_m[front_m][a]];
      end
      return {chk, hs, vs, rgb};
   endfunction

   task automatic model_restart();
      n         = 0;
      front_m   = 1'b0;
      pending_m = 1'b0;
      for (int i = 0; i < PN; i++) pal_m[i] = (i == 0) ? 12'h000 : 12'hFFF;
      exp_q.delete();
      repeat (3) exp_q.push_back(15'h3000);
   endtask

   // ---- driver ----
   task automatic idle_inputs();
      wr_we    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      swap_req = 1'b0;
      pal_we   = 1'b0;
      pal_idx  = '0;
      pal_rgb  = 12'h000;
   endtask

   task automatic drive_inputs();
      bit pal_ok;
      idle_inputs();
      if (!seg_b && front_m) begin
         // Fill the new back buffer; pixels around fb 5 and FB_WIDTH+3 are pinned.
         if (fill_idx < FBS) begin
            wr_we   = 1'b1;
            wr_addr = AW'(fill_idx);
            if (fill_idx == 5 || fill_idx == FBW + 3) wr_data = DW'(1);
            else if (fill_idx == 4 || fill_idx == 6 || fill_idx == FBW + 2 || fill_idx == FBW + 4)
               wr_data = '0;
            else wr_data = DW'($urandom_range(0, PN - 1));
            fill_idx++;
         end
      end else if ($urandom_range(0, 3) == 0) begin
         wr_we   = 1'b1;
         wr_addr = AW'($urandom_range(0, FBS - 1));
         wr_data = DW'($urandom);
      end
      if (!seg_b && n == 10) swap_req = 1'b1;
      if (seg_b && !(n >= FRAME + VA * HT && n < 3 * FRAME) && $urandom_range(0, 199) == 0)
         swap_req = 1'b1;
      if (seg_b && n == VBS2) swap_req = 1'b1;
      pal_ok = (n == 0) || !is_active(n - 1);
      if (seg_b && n < 4 * HT) pal_ok = 1'b0;
      if (pal_ok && $urandom_range(0, 7) == 0) begin
         pal_we  = 1'b1;
         pal_idx = DW'($urandom);
         pal_rgb = 12'($urandom);
      end
      if (seg_b && n == 0) begin
         pal_we  = 1'b1;
         pal_idx = DW'(1);
         pal_rgb = 12'hA5C;
      end
   endtask

   // ---- scoreboard: called on the falling edge of cycle n ----
   task automatic score_cycle();
      logic [14:0] e;
      bit          vbs;
      vbs = (n % HT == 0) && ((n / HT) % VT == VA);
      if (pal_we) pal_m[pal_idx] = pal_rgb;
      e = exp_q.pop_front();
      check("hs", vga_hs, e[13]);
      check("vs", vga_vs, e[12]);
      if (e[14]) check("rgb", {vga_r, vga_g, vga_b}, e[11:0]);
      check("vblank_start", vblank_start, vbs);
      check("front_sel", front_sel, front_m);
      check("swap_pending", swap_pending, pending_m);
      if (vblank_start) vbs_seen++;
      exp_q.push_back(model_pins(n));
      if (seg_b) begin
         if (n == 11 || n == 15 || n == 2 * HT + 8)
            check("scan_neighbour", {vga_r, vga_g, vga_b}, 12'h000);
         if (n == 13 || n == 14 || n == HT + 13)
            check("scan_px5", {vga_r, vga_g, vga_b}, 12'hA5C);
         if (n == 2 * HT + 9 || n == 2 * HT + 10 || n == 3 * HT + 9 || n == 3 * HT + 10)
            check("scale_px", {vga_r, vga_g, vga_b}, 12'hA5C);
         if (n == VBS2 + 1) check("defer_pending", swap_pending, 1);
         if (n == 3 * FRAME + VA * HT + 1) check("defer_served", swap_pending, 0);
      end
      if (wr_we) begin
         mem_m[!front_m][wr_addr]   = wr_data;
         known_m[!front_m][wr_addr] = 1'b1;
      end
      if (vbs) vbs_exp++;
      if (vbs && pending_m) begin
         front_m   = !front_m;
         pending_m = swap_req;
      end else if (swap_req) begin
         pending_m = 1'b1;
      end
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
      check({tag, "_hs"}, vga_hs, 1);
      check({tag, "_vs"}, vga_vs, 1);
      check({tag, "_front"}, front_sel, 0);
      check({tag, "_pending"}, swap_pending, 0);
      check({tag, "_vbs"}, vblank_start, 0);
   endtask

   task automatic run_until(input int last);
      while (n < last) begin
         drive_inputs();
         @(negedge clk);
         score_cycle();
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // ---- main sequence and final report ----
   initial begin
      n_cmp = 0; n_bad = 0; vbs_seen = 0; vbs_exp = 0;
      fill_idx = 0; seg_b = 1'b0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < FBS; i++) known_m[b][i] = 1'b0;
      idle_inputs();
      reset_n = 1'b0;
      model_restart();
      repeat (2) @(posedge clk);
      #1;
      // Buffer 1 is the back buffer while reset holds front_sel at 0.
      for (int i = 0; i < FBS; i++) begin
         wr_we   = 1'b1;
         wr_addr = AW'(i);
         wr_data = DW'($urandom);
         mem_m[1][i]   = wr_data;
         known_m[1][i] = 1'b1;
         @(negedge clk);
         if (i < 4) check_reset_pins("reset");
         @(posedge clk);
         #1;
      end
      idle_inputs();
      reset_n = 1'b1;
      model_restart();
      run_until(FRAME + 5 * HT);
      check("pre_reset_front", front_sel, 1);
      reset_n = 1'b0;
      idle_inputs();
      repeat (3) begin
         @(negedge clk);
         check_reset_pins("midreset");
         @(posedge clk);
         #1;
      end
      reset_n = 1'b1;
      seg_b   = 1'b1;
      model_restart();
      run_until(5 * FRAME);
      check("vbs_count", vbs_seen, vbs_exp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/draw_fb.md
# draw_fb

Double-buffered framebuffer scanout engine for the fluid-simulation display path. It generalises the single-buffer draw block with parametrised VGA timing, multi-bit palette-indexed pixels, integer pixel scaling and frame-synchronous buffer swapping. The simulation writes into a back buffer while the front buffer is scanned out. It runs entirely on the pixel clock; the PLL sits outside this block.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SCALE, 1, integer upscale factor; legal values are 1, 2 and 4
- FB_WIDTH / FB_HEIGHT, H_ACTIVE/SCALE and V_ACTIVE/SCALE, stored image size
- FB_SIZE / FB_ADDRW, FB_WIDTH*FB_HEIGHT and $clog2(FB_SIZE)
- DATAW, 1, bits per pixel (palette index); legal range is 1–4
- INIT_F, "", initial contents file for buffer 0
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- wr_addr  in  FB_ADDRW  back-buffer write address
- wr_data  in  DATAW  pixel index
- wr_we  in  1  write strobe
- swap_req  in  1  single-cycle request to swap buffers at the next vblank
- swap_pending  out  1  a request is latched but not yet serviced
- front_sel  out  1  buffer currently being displayed
- vblank_start  out  1  single-cycle pulse at h=0, v=V_ACTIVE
- pal_we  in  1  palette write strobe
- pal_idx  in  DATAW  palette entry to write
- pal_rgb  in  12  {r,g,b} value to write
- vga_r / vga_g / vga_b  out  4 each  colour outputs
- vga_hs / vga_vs  out  1 each  sync outputs, active-low

## Operation
- **Counters:** h counts 0..H_TOTAL-1; v advances when h wraps and counts 0..V_TOTAL-1. The active region is h<H_ACTIVE and v<V_ACTIVE.
- **Sync pulses:** hs is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs is low for the analogous range of v.
- **Address generation:** no multipliers are used.
  - A sub-pixel counter advances fb_x every SCALE pixels.
  - A sub-line counter adds FB_WIDTH to row_base every SCALE lines.
  - row_base and fb_x clear at v=0 and h=0 respectively.
  - The read address is row_base+fb_x.
- **Buffers:** the read side uses front_sel and the write side uses ~front_sel. A write issued on the swap cycle uses the pre-swap back buffer.
- **Swap handling:**
  - swap_req sets swap_pending.
  - On the vblank_start cycle, if swap_pending is set, front_sel toggles and swap_pending clears.
  - A swap_req arriving on that same cycle is latched for the following vblank.
  - Repeated requests before service coalesce into one.
- **Palette:** the pixel index selects a 2^DATAW × 12-bit palette.
  - Reset contents: entry 0 = 0x000, all other entries = 0xFFF.
  - Writes take effect on the next cycle.
  - A write to the entry being read in the same cycle returns the old value.
- **Blanking:** outside the active region the colour outputs are forced to 0.
- **Reset:** h, v, sub-counters, row_base, front_sel and swap_pending all reset to 0; vga_r/g/b=0; vga_hs=vga_vs=1; vblank_start=0.
  - Asserting reset mid-frame returns the block to h=v=0.
  - Framebuffer RAM contents are not reset.

## Timing
- Pipeline:
  - Stage 0: counters.
  - Stage 1: registered address, plus delayed active, hs and vs.
  - Stage 2: BRAM read data.
  - Stage 3: palette lookup, registered onto the pins.
- Counter state at cycle n appears on vga_* at cycle n+3. Sync and colour are equally delayed.
- vblank_start is not delayed; front_sel changes the cycle after vblank_start.
- A written pixel is visible from the frame after the next serviced swap.
- H_TOTAL=800 and V_TOTAL=525 with the default parameters.

## Structure
- The package draw_pkg holds:
  - the default timing constants;
  - the H_TOTAL/V_TOTAL derivation functions;
  - the rgb12_t typedef;
  - the reset palette function.
- Sub-module draw_timing contains the h/v counters, syncs, active flag and vblank_start.
- The two buffers are existing bram_sdp instances with both clocks tied to clk.
- The palette is a local register array.

## Test plan
- **Reset:** hold reset_n=0 → rgb=0 and hs=vs=1. Release → first hs falling edge at cycle 656+3.
- **Line/frame timing:** hs is low for 96 of every 800 cycles. vs is low for 2 of every 525 lines. vblank_start pulses once per 420000 cycles.
- **Scanout:** buffer 0 holds index 1 at address 5, with palette[1]=0xA5C. Then line 0, pixel 5 outputs 0xA5C at counter cycle 5+3, and neighbouring pixels output 0x000.
- **Scaling (SCALE=2):** the pixel at fb address FB_WIDTH+3 appears at screen (6..7, 2..3).
- **Swap:** write 0xF pattern to the back buffer and pulse swap_req mid-frame. Then swap_pending=1 until vblank_start, front_sel toggles the next cycle, and the pattern is shown in the following frame. A swap_req on the vblank_start cycle is deferred one frame.
- **Reset mid-frame:** at v=200, front_sel=1, assert reset_n. Then front_sel=0, counters restart at 0 and sync reappears with nominal timing.
